reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file. It is the next generation of the team's 3-register/1-port scratch file with a user-input slot.
- 2**ADDR_W-1 writable registers. The top address is a read-only window onto a synchronised user input.
- Two independent combinational read ports and one write port, with optional write-to-read bypass.
- A sequential clear engine zeroes every register, one per cycle.
- Sits between the datapath/ALU and the operator switches.

Parameters:
DATA_W, 8, register and port data width.
ADDR_W, 2, address width; NREGS = 2**ADDR_W-1 storage registers; address 2**ADDR_W-1 = user slot.
BYPASS, 1, 1 = read of the address being written returns wdata the same cycle; 0 = returns old contents.
SYNC_STAGES, 2, flop stages on user_in (0 = direct combinational pass-through, max 3).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
raddr_a  in  ADDR_W  read port A address
rdata_a  out  DATA_W  read port A data (combinational)
raddr_b  in  ADDR_W  read port B address
rdata_b  out  DATA_W  read port B data (combinational)
we  in  1  write request
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
wr_ok  out  1  write accepted this cycle (combinational)
clr  in  1  start sequential clear (level sampled on clk)
busy  out  1  clear in progress (registered)
user_in  in  DATA_W  external user value

Behaviour:
- Reset (rst_n low, asynchronous)
  - All storage registers, user sync flops, clear index and FSM go to 0/IDLE; busy=0.
  - Consequently rdata_a/b = 0 for every address while in reset.
- Read ports
  - Pure combinational mux, zero latency.
  - addr < NREGS → reg[addr]; addr == 2**ADDR_W-1 → user_sync.
  - Both ports independent; same address on both is legal.
- Bypass (BYPASS=1 only)
  - Condition: wr_ok=1 and raddr_x == waddr.
  - rdata_x = wdata for that port, that cycle.
  - Never applies to the user slot.
- Write
  - wr_ok = we & ~busy & ~clr & (waddr != 2**ADDR_W-1).
  - When wr_ok=1, reg[waddr] <= wdata at the next rising edge.
  - Writes to the user slot are silently dropped (wr_ok=0).
- user_sync
  - SYNC_STAGES-deep flop chain on user_in, reset to 0.
  - Latency = SYNC_STAGES cycles.
- Clear FSM, states IDLE and CLEAR
  - IDLE → CLEAR when clr=1 at an edge; idx <= 0.
  - In CLEAR, each edge: reg[idx] <= 0, idx++. After clearing idx = NREGS-1 → IDLE.
  - busy is a registered copy of (state == CLEAR). Clear takes exactly NREGS cycles of busy=1.
  - clr asserted while busy: ignored, no restart.
  - clr held high continuously: re-triggers immediately after returning to IDLE.
  - clr and we in the same IDLE cycle: clear wins, wr_ok=0, write lost.
  - Reads during CLEAR return current contents, i.e. partially cleared, no stall.
- Reset mid-clear: FSM → IDLE, idx=0, all registers 0.
- idx width = ADDR_W. No wrap is possible because NREGS < 2**ADDR_W.

Decomposition:
- Shared package: clear FSM state enum (IDLE, CLEAR); localparams NREGS and USER_ADDR derived from ADDR_W.
- One natural sub-module, sync_chain: parametrised DATA_W × SYNC_STAGES flop pipeline with async active-low reset.
- Reused later for other external inputs.

Test Plan:
- Reset, defaults (ADDR_W=2, DATA_W=8): pulse rst_n low → rdata_a/b = 0x00 at addr 0..2, busy=0; user_in=0x5A → rdata at addr 3 = 0x00, then 0x5A after 2 clk.
- Write/read: write 0x11→r0, 0x22→r1, 0x33→r2 → ports A/B read those values; write to addr 3 → wr_ok=0, addr 3 still shows user value.
- Bypass: BYPASS=1, we with waddr=1, wdata=0xA5, raddr_a=1 → rdata_a=0xA5 that cycle. BYPASS=0 same stimulus → old value, 0xA5 next cycle.
- Clear: fill r0..r2 with 0xFF, pulse clr → busy=1 for 3 cycles; r0, r1, r2 read 0 after cycles 1, 2, 3 respectively. we during busy → wr_ok=0, no change.
- Collision/abort: clr and we (waddr=0, 0x77) in the same cycle → r0 stays 0 after clear. Assert rst_n low in the 2nd clear cycle → busy=0 immediately, all reads 0.
- Scaling: ADDR_W=3, DATA_W=16 → 7 writable regs, addr 7 = user slot, clear lasts 7 cycles.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types and address helpers for reg_file_mp
package reg_file_mp_pkg;

    // Clear engine states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Default geometry of the classic 3-register scratch file
    localparam int DEF_ADDR_W    = 2;

    // Number of writable storage registers for a given address width
    function automatic int calc_nregs(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    // The top address is the read-only user slot
    function automatic int calc_user_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    localparam int DEF_NREGS     = calc_nregs(DEF_ADDR_W);
    localparam int DEF_USER_ADDR = calc_user_addr(DEF_ADDR_W);

endpackage

// File: rtl/reg_file_mp_sync_chain.sv
// rtl/reg_file_mp_sync_chain.sv - parametrised flop pipeline for external inputs
module sync_chain #(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_chain
            logic [DATA_W-1:0] stage_q [STAGES];

            // Shift the input through the stage flops, all cleared on reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < STAGES; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with user slot and clear engine
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 2,
    parameter int BYPASS      = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wr_ok,
    input  logic              clr,
    output logic              busy,
    input  logic [DATA_W-1:0] user_in
);

    localparam int                NREGS     = calc_nregs(ADDR_W);
    localparam logic [ADDR_W-1:0] USER_ADDR = ADDR_W'(calc_user_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              clear_en;
    logic [DATA_W-1:0] user_sync;

    sync_chain #(
        .DATA_W (DATA_W),
        .STAGES (SYNC_STAGES)
    ) u_user_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (user_in),
        .q_o   (user_sync)
    );

    // A write is taken only when the clear engine is neither running nor starting
    assign wr_ok = we & ~busy_q & ~clr & (waddr != USER_ADDR);
    assign busy  = busy_q;

    // Clear FSM: next state, next index and the per-cycle clear strobe
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clear_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                clear_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Clear FSM state, index and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage next state: the clear engine and the write port never overlap
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (clear_en && (idx_q == ADDR_W'(i))) begin
                regs_d[i] = '0;
            end else if (wr_ok && (waddr == ADDR_W'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read port A: user slot by default, storage by address, optional bypass
    always_comb begin
        rdata_a = user_sync;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_a == ADDR_W'(i)) begin
                rdata_a = regs_q[i];
            end
        end
        if ((BYPASS != 0) && wr_ok && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end
    end

    // Read port B: same structure as port A
    always_comb begin
        rdata_b = user_sync;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_b == ADDR_W'(i)) begin
                rdata_b = regs_q[i];
            end
        end
        if ((BYPASS != 0) && wr_ok && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp in three configurations
module tb_reg_file_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] raddr_a, raddr_b, waddr;
    logic       we, clr;
    logic [7:0] wdata, user_in;
    logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic       wr_ok0, wr_ok1, busy0, busy1;

    logic [2:0]  raddr_a2, raddr_b2, waddr2;
    logic        we2, clr2;
    logic [15:0] wdata2, user_in2, rd_a2, rd_b2;
    logic        wr_ok2, busy2;

    reg_file_mp #(.DATA_W(8), .ADDR_W(2), .BYPASS(1), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .raddr_a(raddr_a), .rdata_a(rd_a0),
        .raddr_b(raddr_b), .rdata_b(rd_b0), .we(we), .waddr(waddr),
        .wdata(wdata), .wr_ok(wr_ok0), .clr(clr), .busy(busy0), .user_in(user_in)
    );

    reg_file_mp #(.DATA_W(8), .ADDR_W(2), .BYPASS(0), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .raddr_a(raddr_a), .rdata_a(rd_a1),
        .raddr_b(raddr_b), .rdata_b(rd_b1), .we(we), .waddr(waddr),
        .wdata(wdata), .wr_ok(wr_ok1), .clr(clr), .busy(busy1), .user_in(user_in)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .raddr_a(raddr_a2), .rdata_a(rd_a2),
        .raddr_b(raddr_b2), .rdata_b(rd_b2), .we(we2), .waddr(waddr2),
        .wdata(wdata2), .wr_ok(wr_ok2), .clr(clr2), .busy(busy2), .user_in(user_in2)
    );

    typedef struct {
        int          d;
        int          s;
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int d, input int s, input logic [15:0] v, input string tag);
        exp_t e;
        e.d = d; e.s = s; e.v = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic both(input int s, input logic [15:0] v, input string tag);
        push(0, s, v, {tag, "_d0"});
        push(1, s, v, {tag, "_d1"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] actual(input int d, input int s);
        logic [15:0] r;
        r = 16'hDEAD;
        case (d * 4 + s)
            0:  r = {8'h00, rd_a0};
            1:  r = {8'h00, rd_b0};
            2:  r = {15'h0, wr_ok0};
            3:  r = {15'h0, busy0};
            4:  r = {8'h00, rd_a1};
            5:  r = {8'h00, rd_b1};
            6:  r = {15'h0, wr_ok1};
            7:  r = {15'h0, busy1};
            8:  r = rd_a2;
            9:  r = rd_b2;
            10: r = {15'h0, wr_ok2};
            11: r = {15'h0, busy2};
            default: r = 16'hDEAD;
        endcase
        return r;
    endfunction

    // Monitor: drain pending expectations mid-cycle and compare against the outputs
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [15:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.d, e.s);
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.tag, act, e.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] v;
        rst_n = 1'b0;
        raddr_a = '0; raddr_b = '0; waddr = '0; we = 1'b0; clr = 1'b0;
        wdata = '0; user_in = 8'h5A;
        raddr_a2 = '0; raddr_b2 = '0; waddr2 = '0; we2 = 1'b0; clr2 = 1'b0;
        wdata2 = '0; user_in2 = '0;
        repeat (2) tick();

        // Reset state
        raddr_a = 2'd0; raddr_b = 2'd1;
        both(0, 16'h00, "rst_r0"); both(1, 16'h00, "rst_r1"); both(3, 16'h0, "rst_busy");
        tick();
        raddr_a = 2'd2; raddr_b = 2'd3;
        both(0, 16'h00, "rst_r2"); both(1, 16'h00, "rst_user");
        tick();

        // User slot latency after reset release
        rst_n = 1'b1;
        both(1, 16'h00, "user_lat0");
        tick();
        both(1, 16'h00, "user_lat1");
        tick();
        both(1, 16'h5A, "user_lat2");
        tick();

        // Writes to r0..r2 and a dropped write to the user slot
        we = 1'b1; waddr = 2'd0; wdata = 8'h11;
        both(2, 16'h1, "wr_ok_r0");
        tick();
        waddr = 2'd1; wdata = 8'h22; tick();
        waddr = 2'd2; wdata = 8'h33; tick();
        waddr = 2'd3; wdata = 8'hEE;
        both(2, 16'h0, "wr_ok_user");
        tick();
        we = 1'b0;
        raddr_a = 2'd0; raddr_b = 2'd1;
        both(0, 16'h11, "rd_r0"); both(1, 16'h22, "rd_r1");
        tick();
        raddr_a = 2'd2; raddr_b = 2'd3;
        both(0, 16'h33, "rd_r2"); both(1, 16'h5A, "rd_user_after_wr");
        tick();
        raddr_a = 2'd2; raddr_b = 2'd2;
        both(0, 16'h33, "rd_same_a"); both(1, 16'h33, "rd_same_b");
        tick();

        // Bypass enabled vs disabled
        we = 1'b1; waddr = 2'd1; wdata = 8'hA5; raddr_a = 2'd1; raddr_b = 2'd0;
        push(0, 0, 16'hA5, "byp_on");
        push(1, 0, 16'h22, "byp_off_old");
        both(1, 16'h11, "byp_other_port");
        tick();
        we = 1'b0;
        both(0, 16'hA5, "byp_next");
        tick();
        we = 1'b1; waddr = 2'd3; wdata = 8'hC3; raddr_a = 2'd3;
        both(0, 16'h5A, "no_byp_user");
        tick();
        we = 1'b0;

        // Fill with 0xFF then run a clear
        we = 1'b1; wdata = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            waddr = 2'(i);
            tick();
        end
        we = 1'b0;
        clr = 1'b1;
        both(3, 16'h0, "clr_busy_pre");
        tick();
        clr = 1'b0; raddr_a = 2'd0; raddr_b = 2'd1;
        we = 1'b1; waddr = 2'd2; wdata = 8'h12;
        both(3, 16'h1, "clr_busy1"); both(2, 16'h0, "clr_wr_blocked"); both(0, 16'hFF, "clr_c0_r0");
        tick();
        clr = 1'b1;
        both(3, 16'h1, "clr_busy2"); both(0, 16'h00, "clr_c1_r0"); both(1, 16'hFF, "clr_c1_r1");
        tick();
        clr = 1'b0; raddr_a = 2'd2;
        both(3, 16'h1, "clr_busy3"); both(1, 16'h00, "clr_c2_r1"); both(0, 16'hFF, "clr_c2_r2");
        tick();
        we = 1'b0;
        both(3, 16'h0, "clr_done"); both(0, 16'h00, "clr_c3_r2");
        tick();

        // Clear and write in the same idle cycle: clear wins
        we = 1'b1; waddr = 2'd0; wdata = 8'h55;
        tick();
        wdata = 8'h77; clr = 1'b1;
        both(2, 16'h0, "coll_wr_ok");
        tick();
        clr = 1'b0; we = 1'b0;
        repeat (3) tick();
        raddr_a = 2'd0;
        both(0, 16'h00, "coll_r0"); both(3, 16'h0, "coll_busy");
        tick();

        // Reset during the second clear cycle
        we = 1'b1;
        waddr = 2'd0; wdata = 8'h10; tick();
        waddr = 2'd1; wdata = 8'h20; tick();
        waddr = 2'd2; wdata = 8'h30; tick();
        we = 1'b0;
        clr = 1'b1; tick();
        clr = 1'b0; tick();
        rst_n = 1'b0; raddr_a = 2'd1; raddr_b = 2'd2;
        both(3, 16'h0, "rstmid_busy"); both(0, 16'h00, "rstmid_r1"); both(1, 16'h00, "rstmid_r2");
        tick();
        raddr_a = 2'd0; raddr_b = 2'd3;
        both(0, 16'h00, "rstmid_r0"); both(1, 16'h00, "rstmid_user");
        tick();
        rst_n = 1'b1;
        tick();
        raddr_a = 2'd2;
        both(3, 16'h0, "rstmid_idle"); both(0, 16'h00, "rstmid_r2_after");
        tick();

        // Scaled configuration: 7 registers, user slot at address 7
        user_in2 = 16'hBEEF; raddr_b2 = 3'd7;
        push(2, 1, 16'h0000, "s_user_lat0");
        tick(); tick();
        push(2, 1, 16'hBEEF, "s_user_lat2");
        tick();
        we2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            waddr2 = 3'(i);
            wdata2 = 16'h1000 + 16'(i) * 16'h0111;
            tick();
        end
        waddr2 = 3'd7; wdata2 = 16'h9999;
        push(2, 2, 16'h0, "s_wr_ok_user");
        tick();
        we2 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            raddr_a2 = 3'(i);
            v = 16'h1000 + 16'(i) * 16'h0111;
            push(2, 0, v, $sformatf("s_rd_r%0d", i));
            tick();
        end
        push(2, 1, 16'hBEEF, "s_rd_user");
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            push(2, 3, 16'h1, $sformatf("s_busy_c%0d", k));
            tick();
        end
        raddr_a2 = 3'd6; raddr_b2 = 3'd0;
        push(2, 3, 16'h0, "s_busy_end");
        push(2, 0, 16'h0000, "s_clr_r6");
        push(2, 1, 16'h0000, "s_clr_r0");
        tick();

        repeat (2) tick();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
